// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the core's load/store port.
// One request is accepted at a time. It waits LATENCY cycles, then commits
// the byte/half/word access to internal storage. The response is then held
// until the core accepts it.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           cur_word;
  logic                  acc_err;
  logic [3:0]            byte_en;
  logic [31:0]           store_lanes;
  logic [31:0]           merged_word;
  logic [31:0]           shifted;
  logic [31:0]           load_val;
  logic                  mem_we;

  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign cur_word = mem_q[word_idx];

  // Classify the latched request: illegal size, misalignment, or out-of-range address.
  always_comb begin
    acc_err = 1'b0;
    unique case (size_q)
      SZ_BYTE: acc_err = 1'b0;
      SZ_HALF: acc_err = addr_q[0];
      SZ_WORD: acc_err = (addr_q[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ((addr_q >> ADDR_WIDTH) != '0) begin
      acc_err = 1'b1;
    end
  end

  // Store path: replicate store data across lanes and merge the enabled lanes into the current word.
  always_comb begin
    byte_en     = '0;
    store_lanes = '0;
    unique case (size_q)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << addr_q[1:0];
        store_lanes = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{wdata_q[15:0]}};
      end
      SZ_WORD: begin
        byte_en     = 4'b1111;
        store_lanes = wdata_q;
      end
      default: begin
        byte_en     = '0;
        store_lanes = '0;
      end
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? store_lanes[8*i +: 8] : cur_word[8*i +: 8];
    end
  end

  // Load path: right-align the addressed lanes, then sign- or zero-extend.
  always_comb begin
    shifted  = cur_word >> {addr_q[1:0], 3'b000};
    load_val = '0;
    unique case (size_q)
      SZ_BYTE: load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_val = cur_word;
      default: load_val = '0;
    endcase
  end

  // Request/response sequencing: IDLE accepts, WAIT counts down and commits, RESP holds until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    size_d  = size_q;
    sign_d  = sign_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          size_d  = req_size;
          sign_d  = req_sign;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = acc_err;
          rdata_d = (acc_err || write_q) ? '0 : load_val;
          mem_we  = write_q && !acc_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: not reset; a committed store is a single-edge read-modify-write of one word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance (index 1) for function,
// errors, backpressure and reset abort; a LATENCY=0 instance (index 0) for throughput.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [1:0]  rsp_ready;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_err;
  logic [1:0]  busy;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  time acc_t;
  time t1, t2, t3;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(LAT)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rdata1), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rdata0), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic int qsize(input int w);
    return (w == 1) ? q1.size() : q0.size();
  endfunction

  // Monitors: pop and compare whenever a response handshake is about to happen.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst && rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp1_unexpected: got rdata 0x%08h err %0b with no expectation", rdata1, rsp_err[1]);
      end else begin
        e = q1.pop_front();
        check("rsp1_rdata", rdata1, e.rdata);
        check("rsp1_err", {31'b0, rsp_err[1]}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst && rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp0_unexpected: got rdata 0x%08h err %0b with no expectation", rdata0, rsp_err[0]);
      end else begin
        e = q0.pop_front();
        check("rsp0_rdata", rdata0, e.rdata);
        check("rsp0_err", {31'b0, rsp_err[0]}, {31'b0, e.err});
      end
    end
  end

  // Drive a request to instance w, optionally push its expected response, return #1 after acceptance.
  task automatic issue(input int w, input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [1:0] sz, input logic sg, input logic [31:0] er, input logic ee,
                       input bit push);
    exp_t e;
    int   n;
    e.rdata = er;
    e.err   = ee;
    if (push) begin
      if (w == 1) q1.push_back(e);
      else        q0.push_back(e);
    end
    req_addr     = a;
    req_wdata    = d;
    req_write    = wr;
    req_size     = sz;
    req_sign     = sg;
    req_valid[w] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[w] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) timeout_fail("accept");
    @(posedge clk);
    acc_t = $time;
    #1;
    req_valid[w] = 1'b0;
  endtask

  // Wait for the response of instance w to be consumed; optionally check acceptance-to-valid latency.
  task automatic wait_rsp(input int w, input bit check_lat);
    int n;
    int m;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid[w] && n < 100);
    if (check_lat) check("latency", 32'(n), (w == 1) ? 32'(LAT + 1) : 32'd1);
    m = 0;
    while (qsize(w) != 0 && m < 100) begin
      @(posedge clk);
      #1;
      m++;
    end
    if (m >= 100) timeout_fail("response");
  endtask

  task automatic acc(input int w, input logic [31:0] a, input logic [31:0] d, input logic wr,
                     input logic [1:0] sz, input logic sg, input logic [31:0] er, input logic ee);
    issue(w, a, d, wr, sz, sg, er, ee, 1'b1);
    wait_rsp(w, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    req_size  = '0;
    req_sign  = 1'b0;
    rsp_ready = 2'b11;
    #12;
    check("rst_req_ready", {31'b0, req_ready[1]}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_err", {31'b0, rsp_err[1]}, 32'd0);
    check("rst_busy", {31'b0, busy[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Word store then load
    acc(1, 32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    acc(1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte/half extension
    acc(1, 32'h20, 32'h80FF7F01, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    acc(1, 32'h23, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
    acc(1, 32'h23, 32'h0, 1'b0, 2'b00, 1'b0, 32'h00000080, 1'b0);
    acc(1, 32'h22, 32'h0, 1'b0, 2'b01, 1'b1, 32'hFFFF80FF, 1'b0);
    acc(1, 32'h20, 32'h0, 1'b0, 2'b01, 1'b0, 32'h00007F01, 1'b0);
    acc(1, 32'h21, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0000007F, 1'b0);
    acc(1, 32'h20, 32'h0, 1'b0, 2'b01, 1'b1, 32'h00007F01, 1'b0);
    acc(1, 32'h22, 32'h0, 1'b0, 2'b00, 1'b0, 32'h000000FF, 1'b0);

    // Partial stores
    acc(1, 32'h30, 32'h11223344, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    acc(1, 32'h31, 32'h000000AA, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    acc(1, 32'h32, 32'h0000BBCC, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0);
    acc(1, 32'h30, 32'h0, 1'b0, 2'b10, 1'b0, 32'hBBCCAA44, 1'b0);

    // Errors, memory must stay unchanged
    acc(1, 32'h40, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    acc(1, 32'h41, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1);
    acc(1, 32'h42, 32'h00000055, 1'b1, 2'b10, 1'b0, 32'h0, 1'b1);
    acc(1, 32'h40, 32'h00000000, 1'b1, 2'b11, 1'b0, 32'h0, 1'b1);
    acc(1, 32'h00010000, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1);
    acc(1, 32'h00010040, 32'h00000099, 1'b1, 2'b10, 1'b0, 32'h0, 1'b1);
    acc(1, 32'h41, 32'h000000EE, 1'b1, 2'b01, 1'b0, 32'h0, 1'b1);
    acc(1, 32'h40, 32'h0, 1'b0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

    // Backpressure: response frozen, extra request ignored
    rsp_ready[1] = 1'b0;
    issue(1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid[1] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout_fail("bp_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid[1]}, 32'd1);
      check("bp_rdata", rdata1, 32'hDEADBEEF);
      check("bp_req_ready", {31'b0, req_ready[1]}, 32'd0);
      if (i == 0) begin
        req_addr     = 32'h10;
        req_wdata    = 32'h0BADF00D;
        req_write    = 1'b1;
        req_size     = 2'b10;
        req_valid[1] = 1'b1;
      end
    end
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", {31'b0, req_ready[1]}, 32'd1);
    check("release_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
    check("release_rdata", rdata1, 32'd0);
    check("release_busy", {31'b0, busy[1]}, 32'd0);
    check("bp_queue_drained", 32'(q1.size()), 32'd0);
    acc(1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    // Throughput with LATENCY=0
    acc(0, 32'h60, 32'h00000111, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    issue(0, 32'h60, 32'h00000222, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
    t1 = acc_t;
    issue(0, 32'h60, 32'h0, 1'b0, 2'b10, 1'b0, 32'h00000222, 1'b0, 1'b1);
    t2 = acc_t;
    issue(0, 32'h62, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    t3 = acc_t;
    wait_rsp(0, 1'b0);
    check("thru_1", 32'(t2 - t1), 32'd30);
    check("thru_2", 32'(t3 - t2), 32'd30);

    // Reset abort in WAIT
    acc(1, 32'h50, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    issue(1, 32'h50, 32'h12345678, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_req_ready", {31'b0, req_ready[1]}, 32'd1);
    check("abort_busy", {31'b0, busy[1]}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
    check("abort_rdata", rdata1, 32'd0);
    check("abort_err", {31'b0, rsp_err[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    acc(1, 32'h50, 32'h0, 1'b0, 2'b10, 1'b0, 32'h00000000, 1'b0);

    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q0_empty", 32'(q0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's load/store interface.
- Accepts one request at a time over a valid/ready handshake and applies a programmable wait-state latency.
- Performs byte/half/word stores with byte enables, and loads with sign or zero extension.
- Returns a response over a second valid/ready handshake; lets the core move from ideal single-cycle memory to a stallable, multi-cycle data port.

Parameters:
- ADDR_WIDTH, 16, byte-address bits implemented; storage = 2**(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2, wait cycles between acceptance and commit; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_write  in  1  1 = store, 0 = load (MemWrite).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (SizeSrc).
- req_sign  in  1  1 = sign-extend load, 0 = zero-extend (LoadSign).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned, out of range, or illegal size).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
  - Storage contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch addr/wdata/write/size/sign, load the counter with LATENCY, and go to WAIT.
  - Request inputs are ignored at all other times.
- WAIT:
  - req_ready=0.
  - If counter!=0, decrement it.
  - If counter==0, commit the access on this edge and go to RESP.
- Timing: rsp_valid rises exactly LATENCY+1 edges after the acceptance edge (LATENCY=0: 1 edge).
- Commit, little-endian:
  - Byte index = addr[1:0].
  - Byte store writes only lane addr[1:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all 4 lanes; unwritten lanes are unchanged.
  - Loads select the same lanes, right-align them, then extend per the latched sign (bit 7 or bit 15). Word loads return all 32 bits unmodified.
- Error: rsp_err=1 when any of the following holds:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:ADDR_WIDTH]!=0.
  - On error: no storage write, rsp_rdata=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready=1, clear rsp_valid, rsp_rdata and rsp_err, then go to IDLE.
  - req_ready rises the cycle after the response handshake. A request asserted during that handshake cycle is not accepted; the earliest next acceptance is one edge later.
  - Throughput: one request per LATENCY+3 cycles, with zero backpressure.
- Backpressure: rsp_ready=0 holds RESP indefinitely with outputs frozen.
- Reset mid-operation:
  - Reset in WAIT before the commit edge aborts the request; the store is not performed.
  - Reset in RESP drops the response; a store already committed remains in storage.
- rsp_ready is ignored outside RESP.
- Storage is read-modify-written in a single edge: a store immediately followed by a load to the same address returns the new data.

Test Plan:
- Word store then load, LATENCY=2: store 0xDEADBEEF @0x0010 with rsp_ready=1 -> rsp_valid rises 3 edges after acceptance, err=0, rdata=0. Load word @0x0010 -> rdata=0xDEADBEEF.
- Byte/half extension: store word 0x80FF7F01 @0x20. Then:
  - lb @0x23 sign -> 0xFFFFFF80
  - lbu @0x23 -> 0x00000080
  - lh @0x22 sign -> 0xFFFF80FF
  - lhu @0x20 -> 0x00007F01
- Partial store: word 0x11223344 @0x30, then sb 0xAA @0x31 and sh 0xBBCC @0x32 -> load word @0x30 returns 0xBBCCAA44.
- Errors: each of the following returns rsp_err=1 and rdata=0 with memory unchanged (check by reload):
  - half load @0x41
  - word store 0x55 @0x42
  - size=11 @0x40
  - word load @0x00010000 with ADDR_WIDTH=16
- Backpressure and throughput: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0, a second req_valid is ignored. Release -> req_ready=1 one cycle later. With LATENCY=0, back-to-back requests complete every 3 cycles.
- Reset abort: store 0x12345678 @0x50 (old value 0), assert rst one cycle after acceptance -> outputs reach reset values immediately. Load @0x50 after release -> 0x00000000.
